// File: rtl/pipeline_mem_stage_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
package mem_stage_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;
    localparam int CTR_W       = 8;
endpackage

// File: rtl/pipeline_mem_stage_timeout_ctr.sv
// Wait-cycle counter for an outstanding data-memory access.
// tc flags the last BUSY cycle before the access is abandoned.
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CTR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == CTR_W'(TIMEOUT - 1));
endmodule

// File: rtl/pipeline_mem_stage.sv
// MEM stage: one load/store per instruction over a req/ack port, stalls
// upstream while busy, and registers the write-back result for MEM/WB.
module pipeline_mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mem_to_reg,
    input  logic              mem_write,
    input  logic [15:0]       pc_count,
    input  logic [DATA_W-1:0] RD2,
    input  logic [DATA_W-1:0] aluResult,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_mem_to_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       wb_pc_count,
    output logic              wb_err
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_q, alu_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [15:0]       pc_q, pc_d, wb_pc_q, wb_pc_d;
    logic              load_q, load_d, we_q, we_d;
    logic              wb_valid_q, wb_valid_d, wb_ml_q, wb_ml_d, wb_err_q, wb_err_d;
    logic              busy, mem_op, misaligned, start, ack_hit, timeout_hit, tc;

    always_comb begin
        busy        = (state_q == BUSY);
        mem_op      = in_valid & (mem_to_reg | mem_write);
        misaligned  = (aluResult[1:0] != 2'b00);
        start       = !busy & mem_op & !misaligned;
        ack_hit     = busy & dmem_ack;
        timeout_hit = busy & !dmem_ack & tc;
    end

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk  (clk),
        .rst_n(rst),
        .clr  (start),
        .en   (busy & !dmem_ack),
        .tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (ack_hit | timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Upstream may advance in the ack or time-out cycle of an access.
    always_comb begin
        stall      = start | (busy & !dmem_ack & !tc);
        dmem_req   = busy;
        dmem_we    = busy & we_q;
        dmem_addr  = alu_q[ADDR_W+1:2];
        dmem_wdata = wdata_q;
    end

    always_comb begin
        alu_d   = alu_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        load_d  = load_q;
        we_d    = we_q;
        if (start) begin
            alu_d   = aluResult;
            wdata_d = RD2;
            pc_d    = pc_count;
            load_d  = mem_to_reg;
            we_d    = mem_write & !mem_to_reg;
        end
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_ml_d    = wb_ml_q;
        wb_data_d  = wb_data_q;
        wb_pc_d    = wb_pc_q;
        wb_err_d   = wb_err_q;
        if (!busy && in_valid && !start) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = pc_count;
            wb_ml_d    = mem_op & mem_to_reg;
            wb_err_d   = mem_op;
            wb_data_d  = mem_op ? '0 : aluResult;
        end else if (ack_hit || timeout_hit) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = pc_q;
            wb_ml_d    = load_q;
            wb_err_d   = timeout_hit;
            wb_data_d  = timeout_hit ? '0 : (load_q ? dmem_rdata : alu_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            alu_q      <= '0;
            wdata_q    <= '0;
            pc_q       <= '0;
            load_q     <= 1'b0;
            we_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_ml_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_pc_q    <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_q      <= alu_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            load_q     <= load_d;
            we_q       <= we_d;
            wb_valid_q <= wb_valid_d;
            wb_ml_q    <= wb_ml_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_mem_to_reg = wb_ml_q;
    assign wb_data       = wb_data_q;
    assign wb_pc_count   = wb_pc_q;
    assign wb_err        = wb_err_q;
endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Randomized bench for pipeline_mem_stage with a transaction-level model:
// each issued instruction predicts its write-back record and memory request.
module tb_pipeline_mem_stage;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, mem_to_reg = 1'b0, mem_write = 1'b0;
    logic [15:0]   pc_count = '0;
    logic [DW-1:0] RD2 = '0, aluResult = '0;
    logic          stall, dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata, wb_data;
    logic          dmem_ack;
    logic          wb_valid, wb_mem_to_reg, wb_err;
    logic [15:0]   wb_pc_count;

    pipeline_mem_stage #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .pc_count(pc_count), .RD2(RD2), .aluResult(aluResult),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_data(wb_data),
        .wb_pc_count(wb_pc_count), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        ml;
        logic        err;
        logic [15:0] pc;
    } wb_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  ack_cycle;
    } plan_t;

    wb_t   exp_q[$];
    plan_t plan_q[$];
    plan_t act_plan = '0;
    wb_t   last_wb = '0;
    int    total = 0;
    int    bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    // Memory responder: acks on the planned BUSY cycle, otherwise stays silent
    // while busy and occasionally sends stray acks while idle.
    initial begin
        int busy_n;
        busy_n = 0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (!rst || !dmem_req) begin
                busy_n = 0;
                if (rst && $urandom_range(0, 7) == 0) dmem_ack = 1'b1;
            end else begin
                if (busy_n == 0) begin
                    chk("plan_avail", 32'(plan_q.size() != 0), 32'd1);
                    if (plan_q.size() != 0) act_plan = plan_q.pop_front();
                end
                busy_n++;
                if (int'(act_plan.ack_cycle) == busy_n) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = act_plan.rdata;
                end
            end
        end
    end

    // Compare process: retirement timing, write-back fields, request fields.
    logic adv_prev = 1'b0;
    logic have_last = 1'b0;
    int   req_cnt = 0;
    always @(negedge clk) begin
        wb_t e;
        int  exp_len;
        if (!rst) begin
            adv_prev  = 1'b0;
            have_last = 1'b0;
            req_cnt   = 0;
        end else begin
            chk("wb_valid_timing", wb_valid, adv_prev);
            if (wb_valid) begin
                chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_mem_to_reg", wb_mem_to_reg, e.ml);
                    chk("wb_err", wb_err, e.err);
                    chk("wb_pc_count", wb_pc_count, e.pc);
                    last_wb   = e;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk("hold_data", wb_data, last_wb.data);
                chk("hold_err", wb_err, last_wb.err);
                chk("hold_pc", wb_pc_count, last_wb.pc);
            end
            if (dmem_req) begin
                req_cnt++;
                chk("dmem_addr", dmem_addr, act_plan.addr);
                chk("dmem_we", dmem_we, act_plan.we);
                if (act_plan.we) chk("dmem_wdata", dmem_wdata, act_plan.wdata);
            end else if (req_cnt > 0) begin
                exp_len = (act_plan.ack_cycle >= 1 && int'(act_plan.ack_cycle) <= TO)
                          ? int'(act_plan.ack_cycle) : TO;
                chk("req_length", req_cnt, exp_len);
                req_cnt = 0;
            end
            adv_prev = in_valid && !stall;
        end
    end

    // Present one instruction (caller is just after a rising edge) and hold it
    // until upstream may advance; reports stall/request cycles seen.
    task automatic issue(input logic ml, input logic mw, input logic [15:0] pc,
                         input logic [31:0] rd2, input logic [31:0] alu,
                         input int ack_cycle, input logic [31:0] rdata,
                         output int sc, output int rc, output logic [15:0] sa,
                         output logic sw, output logic [31:0] swd);
        wb_t   e;
        plan_t p;
        logic  memop, done;
        int    guard;
        memop  = ml | mw;
        e.pc   = pc;
        e.ml   = memop & ml;
        e.err  = 1'b0;
        e.data = alu;
        if (memop) begin
            if (alu[1:0] != 2'b00) begin
                e.err  = 1'b1;
                e.data = '0;
            end else begin
                p.addr = alu[17:2];
                p.we = mw & !ml;
                p.wdata = rd2;
                p.rdata = rdata;
                p.ack_cycle = 8'(ack_cycle);
                plan_q.push_back(p);
                if (ack_cycle >= 1 && ack_cycle <= TO) begin
                    e.data = ml ? rdata : alu;
                end else begin
                    e.err  = 1'b1;
                    e.data = '0;
                end
            end
        end
        exp_q.push_back(e);
        in_valid = 1'b1; mem_to_reg = ml; mem_write = mw;
        pc_count = pc; RD2 = rd2; aluResult = alu;
        sc = 0; rc = 0; sa = '0; sw = 1'b0; swd = '0; guard = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (dmem_req) begin
                rc++; sa = dmem_addr; sw = dmem_we; swd = dmem_wdata;
            end
            if (!stall) begin
                done = 1'b1;
            end else begin
                sc++;
                guard++;
                if (guard > 50) begin
                    chk("issue_bound", 32'(guard), 32'd50);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; mem_to_reg = 1'($urandom); mem_write = 1'($urandom);
        RD2 = $urandom; aluResult = $urandom; pc_count = 16'($urandom);
    endtask

    initial begin
        int          sc, rc, typ, ack;
        logic [15:0] sa;
        logic        sw;
        logic [31:0] swd, alu;
        logic        ml, mw;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_err", wb_err, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 1'b0, 16'h0010, 32'h0, 32'h0000_00A5, 0, 32'h0, sc, rc, sa, sw, swd);
        chk("pt_stall", sc, 0);
        chk("pt_req", rc, 0);
        chk("pt_wb_valid", wb_valid, 1'b1);
        chk("pt_wb_data", wb_data, 32'h0000_00A5);
        chk("pt_wb_pc", wb_pc_count, 16'h0010);

        issue(1'b1, 1'b0, 16'h0014, 32'h0, 32'h0000_0040, 4, 32'hDEAD_BEEF, sc, rc, sa, sw, swd);
        chk("ld_stall_cycles", sc, 4);
        chk("ld_addr", sa, 16'h0010);
        chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("ld_wb_ml", wb_mem_to_reg, 1'b1);

        issue(1'b0, 1'b1, 16'h0018, 32'h0000_1234, 32'h0000_0008, 1, 32'h0, sc, rc, sa, sw, swd);
        chk("st_stall_cycles", sc, 1);
        chk("st_we", sw, 1'b1);
        chk("st_addr", sa, 16'h0002);
        chk("st_wdata", swd, 32'h0000_1234);
        chk("st_wb_valid_c2", wb_valid, 1'b1);

        issue(1'b1, 1'b0, 16'h001C, 32'h0, 32'h0000_0041, 1, 32'h0, sc, rc, sa, sw, swd);
        chk("mis_req", rc, 0);
        chk("mis_stall", sc, 0);
        chk("mis_wb_err", wb_err, 1'b1);

        issue(1'b1, 1'b0, 16'h0020, 32'h0, 32'h0000_0100, 0, 32'h0, sc, rc, sa, sw, swd);
        chk("to_req_cycles", rc, 4);
        chk("to_wb_err", wb_err, 1'b1);
        chk("to_wb_data", wb_data, 32'h0);
        issue(1'b0, 1'b1, 16'h0024, 32'h0000_5555, 32'h0000_0200, 2, 32'h0, sc, rc, sa, sw, swd);
        chk("after_to_stall", sc, 2);
        chk("after_to_err", wb_err, 1'b0);

        // Reset in the middle of an access: the load is discarded.
        plan_q.push_back('{addr: 16'h0030, we: 1'b0, wdata: 32'h0, rdata: 32'h0, ack_cycle: 8'd0});
        in_valid = 1'b1; mem_to_reg = 1'b1; mem_write = 1'b0;
        aluResult = 32'h0000_00C0; pc_count = 16'h0028;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("midrst_req_before", dmem_req, 1'b1);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_req", dmem_req, 1'b0);
        chk("midrst_wb_valid", wb_valid, 1'b0);
        chk("midrst_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue(1'b0, 1'b0, 16'h002C, 32'h0, 32'h0000_0077, 0, 32'h0, sc, rc, sa, sw, swd);
        chk("post_rst_stall", sc, 0);
        chk("post_rst_wb_data", wb_data, 32'h0000_0077);

        for (int i = 0; i < 300; i++) begin
            typ = $urandom_range(0, 4);
            alu = $urandom;
            ack = $urandom_range(0, 6);
            ml = 1'b0;
            mw = 1'b0;
            case (typ)
                0: begin ml = 1'b0; mw = 1'b0; end
                1: begin
                    ml = 1'($urandom);
                    mw = !ml;
                    alu[1:0] = 2'($urandom_range(1, 3));
                end
                2: begin ml = 1'b1; mw = 1'b0; alu[1:0] = 2'b00; end
                3: begin ml = 1'b0; mw = 1'b1; alu[1:0] = 2'b00; end
                default: begin ml = 1'b1; mw = 1'b1; alu[1:0] = 2'b00; end
            endcase
            issue(ml, mw, 16'($urandom), $urandom, alu, ack, $urandom, sc, rc, sa, sw, swd);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("exp_drain", exp_q.size(), 0);
        chk("plan_drain", plan_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
